// File: rtl/alu_seq_pkg.sv
// alu_seq_pkg
//   Shared definitions for the sequential ALU: the 16-entry opcode map and
//   the controller state encoding. Imported by alu_seq and alu_seq_mul.
package alu_seq_pkg;

    typedef enum logic [3:0] {
        OP_ANDR = 4'h0,  // AND-reduce A
        OP_XORR = 4'h1,  // XOR-reduce A
        OP_ORR  = 4'h2,  // OR-reduce A
        OP_AND  = 4'h3,
        OP_OR   = 4'h4,
        OP_XOR  = 4'h5,
        OP_ADD  = 4'h6,
        OP_SUB  = 4'h7,
        OP_MUL  = 4'h8,
        OP_EQ   = 4'h9,
        OP_GT   = 4'hA,
        OP_LT   = 4'hB,
        OP_SHR  = 4'hC,
        OP_SHL  = 4'hD,
        OP_ANDN = 4'hE,  // A & ~B
        OP_NOT  = 4'hF   // ~A
    } opcode_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        DONE = 2'd2
    } state_e;

endpackage

// File: rtl/alu_seq_mul.sv
// alu_seq_mul
//   Unsigned shift-add multiplier, one multiplier bit per cycle, WIDTH cycles
//   per product. The first partial product is folded into the start cycle so
//   done pulses at the end of the WIDTH-th cycle.
//   Ports:
//     clk, rst_n : clock, asynchronous active-low reset
//     start      : load operands and begin a product (ignored while busy)
//     a, b       : multiplicand, multiplier
//     done       : one-cycle pulse, product valid
//     product    : 2*WIDTH-bit product, valid when done is high
module alu_seq_mul
    import alu_seq_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic               done,
    output logic [2*WIDTH-1:0] product
);

    localparam int CW = $clog2(WIDTH);

    logic [WIDTH-1:0]   mcand_q;
    logic [2*WIDTH-1:0] prod_q;
    logic [CW-1:0]      cnt_q;
    logic               busy_q;
    logic               done_q;

    // One shift-add step: the upper half accumulates the multiplicand when the
    // current multiplier LSB (p[0]) is set, then the whole pair shifts right.
    // The multiplier is consumed from the low half as the product fills in.
    function automatic logic [2*WIDTH-1:0] step(input logic [2*WIDTH-1:0] p,
                                                input logic [WIDTH-1:0]   m);
        logic [WIDTH:0] s;
        s = {1'b0, p[2*WIDTH-1:WIDTH]} + (p[0] ? {1'b0, m} : {(WIDTH+1){1'b0}});
        return {s, p[WIDTH-1:1]};
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mcand_q <= '0;
            prod_q  <= '0;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (start && !busy_q) begin
                mcand_q <= a;
                prod_q  <= step({{WIDTH{1'b0}}, b}, a);
                cnt_q   <= CW'(WIDTH - 1);
                busy_q  <= 1'b1;
            end else if (busy_q) begin
                prod_q <= step(prod_q, mcand_q);
                cnt_q  <= cnt_q - CW'(1);
                if (cnt_q == CW'(1)) begin
                    busy_q <= 1'b0;
                    done_q <= 1'b1;
                end
            end
        end
    end

    assign done    = done_q;
    assign product = prod_q;

endmodule

// File: rtl/alu_seq.sv
// alu_seq
//   Sequential 16-operation ALU with valid/ready handshakes on both sides.
//   Single-cycle ops complete one cycle after accept; MUL uses the iterative
//   multiplier and completes WIDTH+1 cycles after accept. Results are held in
//   DONE until the consumer takes them.
//   Ports:
//     clk, rst_n          : clock, asynchronous active-low reset
//     in_valid, in_ready  : request handshake (ready only in IDLE)
//     a, b, opcode        : operands and operation, captured at accept
//     out_valid, out_ready: result handshake
//     result, result_hi   : low / high result word (high only non-zero for MUL)
//     carry, zero         : ADD carry / SUB borrow; {result_hi,result}==0
module alu_seq
    import alu_seq_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [3:0]       opcode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic [WIDTH-1:0] result_hi,
    output logic             carry,
    output logic             zero
);

    localparam int SHW = $clog2(WIDTH);

    state_e             state_q, state_d;
    logic [WIDTH-1:0]   res_q, res_d;
    logic [WIDTH-1:0]   hi_q, hi_d;
    logic               carry_q, carry_d;
    logic               zero_q, zero_d;

    logic               accept;
    opcode_e            op;
    logic [WIDTH-1:0]   alu_res;
    logic               alu_c;
    logic [WIDTH:0]     sum;
    logic [SHW-1:0]     sh;
    logic               mul_start;
    logic               mul_done;
    logic [2*WIDTH-1:0] mul_prod;

    function automatic logic [WIDTH-1:0] zext1(input logic bit_in);
        return {{(WIDTH-1){1'b0}}, bit_in};
    endfunction

    // Gating with rst_n keeps in_ready low while reset is asserted even though
    // the state register already sits in IDLE.
    assign in_ready  = rst_n && (state_q == IDLE);
    assign accept    = in_valid && in_ready;
    assign op        = opcode_e'(opcode);
    assign mul_start = accept && (op == OP_MUL);
    assign out_valid = (state_q == DONE);

    alu_seq_mul #(.WIDTH(WIDTH)) u_mul (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (mul_start),
        .a       (a),
        .b       (b),
        .done    (mul_done),
        .product (mul_prod)
    );

    // Single-cycle datapath, evaluated on the live inputs in the accept cycle.
    always_comb begin
        alu_res = '0;
        alu_c   = 1'b0;
        sum     = {1'b0, a} + {1'b0, b};
        sh      = b[SHW-1:0];
        case (op)
            OP_ANDR: alu_res = zext1(&a);
            OP_XORR: alu_res = zext1(^a);
            OP_ORR:  alu_res = zext1(|a);
            OP_AND:  alu_res = a & b;
            OP_OR:   alu_res = a | b;
            OP_XOR:  alu_res = a ^ b;
            OP_ADD: begin
                alu_res = sum[WIDTH-1:0];
                alu_c   = sum[WIDTH];
            end
            OP_SUB: begin
                alu_res = a - b;
                alu_c   = (a < b);
            end
            OP_MUL:  alu_res = '0;
            OP_EQ:   alu_res = zext1(a == b);
            OP_GT:   alu_res = zext1(a > b);
            OP_LT:   alu_res = zext1(a < b);
            OP_SHR:  alu_res = a >> sh;
            OP_SHL:  alu_res = a << sh;
            OP_ANDN: alu_res = a & ~b;
            OP_NOT:  alu_res = ~a;
            default: alu_res = '0;
        endcase
    end

    always_comb begin
        state_d = state_q;
        res_d   = res_q;
        hi_d    = hi_q;
        carry_d = carry_q;
        zero_d  = zero_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    if (op == OP_MUL) begin
                        state_d = MUL;
                    end else begin
                        state_d = DONE;
                        res_d   = alu_res;
                        hi_d    = '0;
                        carry_d = alu_c;
                        zero_d  = (alu_res == '0);
                    end
                end
            end
            MUL: begin
                if (mul_done) begin
                    state_d       = DONE;
                    {hi_d, res_d} = mul_prod;
                    carry_d       = 1'b0;
                    zero_d        = (mul_prod == '0);
                end
            end
            DONE: begin
                if (out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            res_q   <= '0;
            hi_q    <= '0;
            carry_q <= 1'b0;
            zero_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            res_q   <= res_d;
            hi_q    <= hi_d;
            carry_q <= carry_d;
            zero_q  <= zero_d;
        end
    end

    assign result    = res_q;
    assign result_hi = hi_q;
    assign carry     = carry_q;
    assign zero      = zero_q;

endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq
//   Directed, table-driven bench for alu_seq at WIDTH=8, plus hand-written
//   sequences for output back-pressure and reset during a multiply.
module tb_alu_seq;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [3:0]   opcode;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] result;
    logic [W-1:0] result_hi;
    logic         carry;
    logic         zero;

    int n_vec  = 0;
    int n_cmp  = 0;
    int n_fail = 0;

    typedef struct {
        logic [3:0]   op;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] res;
        logic [W-1:0] hi;
        logic         c;
        logic         z;
    } vec_t;

    vec_t tbl[$];

    alu_seq #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .opcode    (opcode),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .result_hi (result_hi),
        .carry     (carry),
        .zero      (zero)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Wait (bounded) for in_ready, present the request for one rising edge,
    // return at the falling edge after the accept with in_valid dropped.
    task automatic issue(input logic [3:0] op, input logic [W-1:0] av, input logic [W-1:0] bv);
        int w;
        w = 0;
        while (!in_ready && w < 50) begin
            @(negedge clk);
            w++;
        end
        chk("in_ready before accept", in_ready, 1);
        in_valid = 1'b1;
        opcode   = op;
        a        = av;
        b        = bv;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        a        = 8'h5A;
        b        = 8'hA5;
        opcode   = 4'h0;
    endtask

    // Count falling edges from accept until out_valid; in_ready must stay low.
    task automatic wait_out(input string tag, output int lat);
        lat = 1;
        while (!out_valid && lat < 40) begin
            chk({tag, " in_ready busy"}, in_ready, 0);
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic handshake(input string tag);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk({tag, " out_valid after take"}, out_valid, 0);
        chk({tag, " in_ready after take"}, in_ready, 1);
    endtask

    task automatic run_vec(input vec_t v, input string tag);
        int lat;
        n_vec++;
        issue(v.op, v.a, v.b);
        wait_out(tag, lat);
        chk({tag, " latency"}, 16'(lat), (v.op == 4'h8) ? 16'd9 : 16'd1);
        chk({tag, " result"}, {8'h0, result}, {8'h0, v.res});
        chk({tag, " result_hi"}, {8'h0, result_hi}, {8'h0, v.hi});
        chk({tag, " carry"}, {15'h0, carry}, {15'h0, v.c});
        chk({tag, " zero"}, {15'h0, zero}, {15'h0, v.z});
        chk({tag, " in_ready in DONE"}, in_ready, 0);
        handshake(tag);
    endtask

    initial begin
        int lat;
        logic [W-1:0] held_res;

        //                op    a      b      res    hi     c     z
        tbl.push_back('{4'h0, 8'hFF, 8'h00, 8'h01, 8'h00, 1'b0, 1'b0});
        tbl.push_back('{4'h0, 8'hFE, 8'h00, 8'h00, 8'h00, 1'b0, 1'b1});
        tbl.push_back('{4'h1, 8'h07, 8'h00, 8'h01, 8'h00, 1'b0, 1'b0});
        tbl.push_back('{4'h2, 8'h00, 8'hFF, 8'h00, 8'h00, 1'b0, 1'b1});
        tbl.push_back('{4'h3, 8'hF0, 8'h3C, 8'h30, 8'h00, 1'b0, 1'b0});
        tbl.push_back('{4'h4, 8'hF0, 8'h0F, 8'hFF, 8'h00, 1'b0, 1'b0});
        tbl.push_back('{4'h5, 8'hAA, 8'hFF, 8'h55, 8'h00, 1'b0, 1'b0});
        tbl.push_back('{4'h6, 8'd200, 8'd255, 8'hC7, 8'h00, 1'b1, 1'b0});
        tbl.push_back('{4'h6, 8'd1, 8'd1, 8'h02, 8'h00, 1'b0, 1'b0});
        tbl.push_back('{4'h7, 8'd5, 8'd7, 8'hFE, 8'h00, 1'b1, 1'b0});
        tbl.push_back('{4'h7, 8'd9, 8'd9, 8'h00, 8'h00, 1'b0, 1'b1});
        tbl.push_back('{4'h8, 8'hFF, 8'hFF, 8'h01, 8'hFE, 1'b0, 1'b0});
        tbl.push_back('{4'h8, 8'h0C, 8'h0A, 8'h78, 8'h00, 1'b0, 1'b0});
        tbl.push_back('{4'h8, 8'h10, 8'h10, 8'h00, 8'h01, 1'b0, 1'b0});
        tbl.push_back('{4'h8, 8'h00, 8'h55, 8'h00, 8'h00, 1'b0, 1'b1});
        tbl.push_back('{4'h9, 8'h05, 8'h05, 8'h01, 8'h00, 1'b0, 1'b0});
        tbl.push_back('{4'h9, 8'h05, 8'h06, 8'h00, 8'h00, 1'b0, 1'b1});
        tbl.push_back('{4'hA, 8'h80, 8'h7F, 8'h01, 8'h00, 1'b0, 1'b0});
        tbl.push_back('{4'hB, 8'h80, 8'h7F, 8'h00, 8'h00, 1'b0, 1'b1});
        tbl.push_back('{4'hC, 8'h80, 8'd7, 8'h01, 8'h00, 1'b0, 1'b0});
        tbl.push_back('{4'hD, 8'h81, 8'd9, 8'h02, 8'h00, 1'b0, 1'b0});
        tbl.push_back('{4'hE, 8'hFF, 8'h0F, 8'hF0, 8'h00, 1'b0, 1'b0});
        tbl.push_back('{4'hF, 8'h0F, 8'h00, 8'hF0, 8'h00, 1'b0, 1'b0});

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        a         = '0;
        b         = '0;
        opcode    = '0;

        // Reset state
        #2;
        chk("reset in_ready", in_ready, 0);
        chk("reset out_valid", out_valid, 0);
        chk("reset result", {result_hi, result}, 16'h0);
        chk("reset carry/zero", {carry, zero}, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("in_ready after release", in_ready, 1);
        @(negedge clk);

        foreach (tbl[i]) run_vec(tbl[i], $sformatf("vec%0d op%0h", i, tbl[i].op));

        // Back-pressure: hold DONE for 5 cycles with a competing request.
        n_vec++;
        issue(4'h7, 8'd5, 8'd7);
        wait_out("stall", lat);
        chk("stall latency", 16'(lat), 16'd1);
        held_res = result;
        chk("stall first result", {8'h0, result}, 16'h00FE);
        in_valid = 1'b1;
        opcode   = 4'h6;
        a        = 8'd1;
        b        = 8'd1;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk($sformatf("stall out_valid c%0d", k), out_valid, 1);
            chk($sformatf("stall in_ready c%0d", k), in_ready, 0);
            chk($sformatf("stall result c%0d", k), {8'h0, result}, {8'h0, held_res});
            chk($sformatf("stall carry c%0d", k), carry, 1);
            chk($sformatf("stall hi/zero c%0d", k), {result_hi, 7'h0, zero}, 16'h0);
        end
        in_valid = 1'b0;
        handshake("stall");
        chk("stall request not taken", {8'h0, result}, 16'h00FE);
        @(negedge clk);
        chk("stall stays idle", out_valid, 0);

        // Reset in the middle of a multiply.
        n_vec++;
        issue(4'h8, 8'hFF, 8'hFF);
        repeat (3) @(negedge clk);
        chk("pre-reset in MUL", {out_valid, in_ready}, 0);
        rst_n = 1'b0;
        #1;
        chk("midmul rst result", {result_hi, result}, 16'h0);
        chk("midmul rst carry/zero", {carry, zero}, 0);
        chk("midmul rst out_valid", out_valid, 0);
        chk("midmul rst in_ready", in_ready, 0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("midmul in_ready after release", in_ready, 1);
        repeat (10) @(negedge clk);
        chk("no stale mul result", {out_valid, result_hi, result}, 0);
        run_vec('{4'h6, 8'd1, 8'd1, 8'h02, 8'h00, 1'b0, 1'b0}, "post-reset add");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
